// File: rtl/cpu_io_pkg.sv
// Shared definitions for the system-bus I/O responder: register offsets
// inside the I/O window and the switch debounce state encoding.
package cpu_io_pkg;

  // Word offsets from IO_BASE
  localparam int unsigned SW_DATA_OFF     = 0;
  localparam int unsigned STATUS_OFF      = 1;
  localparam int unsigned DISP_OFF        = 2;
  localparam int unsigned IO_WINDOW_WORDS = 3;

  // One debounce FSM serves the whole switch word
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    ACCEPT   = 2'd2
  } debounce_state_e;

endpackage

// File: rtl/switch_debounce.sv
// Switch synchroniser and word-wide debouncer. Raw switches pass through
// two flops per bit. A new sampled value is accepted only after it has
// been seen on DEBOUNCE_CYCLES consecutive clocks. 'value' holds the
// accepted word; 'accept' is high for the single cycle in which 'value'
// is updated at the closing edge. 'state' is exported for observation.
module switch_debounce
  import cpu_io_pkg::*;
#(
  parameter int unsigned WORD_W          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [WORD_W-1:0] switches,
  output logic [WORD_W-1:0] value,
  output logic            accept,
  output debounce_state_e state
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic [WORD_W-1:0] sync_q1;
  logic [WORD_W-1:0] s_sync;
  logic [WORD_W-1:0] s_prev;
  logic [CNT_W-1:0]  cnt;
  logic              s_changed;

  assign s_changed = (s_sync != s_prev);
  assign accept    = (state == ACCEPT);

  // Two-flop synchroniser plus one-sample history for change detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      s_sync  <= '0;
      s_prev  <= '0;
    end else begin
      sync_q1 <= switches;
      s_sync  <= sync_q1;
      s_prev  <= s_sync;
    end
  end

  // Debounce FSM; cnt is the length of the current run of identical
  // samples, so the sample that starts a run already counts as one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      value <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (s_sync != value) begin
            cnt   <= CNT_ONE;
            state <= (DEBOUNCE_CYCLES == 1) ? ACCEPT : COUNTING;
          end
        end
        COUNTING: begin
          if (s_changed) begin
            if (s_sync == value) begin
              // Bounced back to the accepted value: nothing to report
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= CNT_ONE;
            end
          end else if (cnt >= CNT_LAST) begin
            cnt   <= CNT_MAX;
            state <= ACCEPT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ACCEPT: begin
          // s_prev is the sample that completed the stable run, so a
          // change arriving during this cycle cannot leak in unfiltered
          value <= s_prev;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sysbus_io_responder.sv
// Memory-mapped I/O responder on the CPU system bus. Exposes the debounced
// switch word, a new-data status flag and a writable display register in a
// three-word window starting at IO_BASE.
//
// Bus protocol: a transfer occurs in any cycle where CS is high and the
// address falls inside the window. Reads complete combinationally in that
// same cycle (the responder drives sysbus only then); writes commit on the
// rising edge that ends the cycle. There are no wait states or back-pressure,
// so every selected cycle is a completed transfer.
module sysbus_io_responder
  import cpu_io_pkg::*;
#(
  parameter int unsigned     WORD_W          = 8,
  parameter int unsigned     OP_W            = 3,
  parameter logic [WORD_W-1:0] IO_BASE       = 8'hF0,
  parameter int unsigned     DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] address,
  input  logic              CS,
  input  logic              R_NW,
  inout  wire  [WORD_W-1:0] sysbus,
  input  logic [WORD_W-1:0] switches,
  output logic [WORD_W-1:0] display,
  output logic              new_data
);

  logic [WORD_W-1:0] offset;
  logic [WORD_W-1:0] sw_data;
  logic [WORD_W-1:0] disp;
  logic [WORD_W-1:0] rd_data;
  logic              sel;
  logic              rd_drive;
  logic              rd_sw;
  logic              wr_disp;
  logic              accept;
  debounce_state_e   db_state;

  // Offset arithmetic keeps the window check to one compare
  assign offset   = address - IO_BASE;
  assign sel      = CS && (offset < WORD_W'(IO_WINDOW_WORDS));
  assign rd_drive = sel && R_NW && !reset;
  assign rd_sw    = sel && R_NW && (offset == WORD_W'(SW_DATA_OFF));
  assign wr_disp  = sel && !R_NW && (offset == WORD_W'(DISP_OFF));

  assign display = disp;
  assign sysbus  = rd_drive ? rd_data : {WORD_W{1'bz}};

  switch_debounce #(
    .WORD_W          (WORD_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock    (clock),
    .reset    (reset),
    .switches (switches),
    .value    (sw_data),
    .accept   (accept),
    .state    (db_state)
  );

  // Read mux for the three window registers
  always_comb begin
    rd_data = '0;
    if (offset == WORD_W'(SW_DATA_OFF)) begin
      rd_data = sw_data;
    end else if (offset == WORD_W'(STATUS_OFF)) begin
      rd_data = {{(WORD_W-1){1'b0}}, new_data};
    end else if (offset == WORD_W'(DISP_OFF)) begin
      rd_data = disp;
    end
  end

  // Display register; the other window words are read-only
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp <= '0;
    end else if (wr_disp) begin
      disp <= sysbus;
    end
  end

  // New-data flag: an accept outranks a same-cycle SW_DATA read so a fresh
  // value is never lost; that read still returns the previous word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      new_data <= 1'b0;
    end else if (accept) begin
      new_data <= 1'b1;
    end else if (rd_sw) begin
      new_data <= 1'b0;
    end
  end

  // The accept pulse must coincide with the debouncer's ACCEPT state
  a_accept_state : assert property (@(posedge clock) disable iff (reset)
    accept == (db_state == ACCEPT));

endmodule
